// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit master.
// Modes are encoded as {CPOL, CPHA}.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TRAIL = 2'd2,
    GAP   = 2'd3
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic [1:0] spiMode(input int cpol, input int cpha);
    return {(cpol != 0), (cpha != 0)};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: emits a one-cycle tick every DIV cycles while run is high,
// restarting from zero whenever run is low so the first tick lands DIV cycles after run rises.
module spi_tick_gen #(
  parameter int DIV = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CntW = $clog2(DIV + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == CntLast);

endmodule

// File: rtl/spi_tx_master.sv
// Parametrised SPI transmit master: accepts a word on a valid/ready handshake and
// frames it on cs_n/sclk/mosi with configurable width, bit order, mode, rate and gap.
module spi_tx_master
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DIV       = 26,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0,
  parameter int CS_GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] SpiMode = spiMode(CPOL, CPHA);
  localparam logic CpolBit = SpiMode[1];
  localparam logic CphaBit = SpiMode[0];
  localparam logic LsbBit  = (LSB_FIRST != 0);

  localparam int BitW = $clog2(DATA_W + 1);
  localparam int GapW = $clog2(CS_GAP + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

  spi_state_e state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic phase_q, phase_d;
  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic csn_q, csn_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic tick;
  logic run;
  logic accept;
  logic [DATA_W-1:0] shifted;
  logic curBit;
  logic nextBit;
  logic firstIn;

  assign run      = (state_q == SHIFT) || (state_q == TRAIL);
  assign tx_ready = (state_q == IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;

  spi_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .run (run),
    .tick(tick)
  );

  // Bit-order aware views of the shift register: the bit on the wire now,
  // the register after one shift, and the bit that shift exposes.
  always_comb begin
    shifted = LsbBit ? (shreg_q >> 1) : (shreg_q << 1);
    curBit  = LsbBit ? shreg_q[0] : shreg_q[DATA_W-1];
    nextBit = LsbBit ? shifted[0] : shifted[DATA_W-1];
    firstIn = LsbBit ? tx_data[0] : tx_data[DATA_W-1];
  end

  // phase_q low means the next sclk edge is leading; bit_q counts trailing edges.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    phase_d = phase_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d = CpolBit;
        csn_d  = 1'b1;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (accept) begin
          state_d = SHIFT;
          shreg_d = tx_data;
          bit_d   = '0;
          phase_d = 1'b0;
          csn_d   = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = CphaBit ? 1'b0 : firstIn;
        end
      end

      SHIFT: begin
        if (tick) begin
          sclk_d  = ~sclk_q;
          phase_d = ~phase_q;
          if (!phase_q) begin
            if (CphaBit) begin
              mosi_d  = curBit;
              shreg_d = shifted;
            end
          end else begin
            bit_d = bit_q + BitW'(1);
            if (bit_q == BitLast) begin
              state_d = TRAIL;
            end else if (!CphaBit) begin
              mosi_d  = nextBit;
              shreg_d = shifted;
            end
          end
        end
      end

      TRAIL: begin
        sclk_d = CpolBit;
        if (tick) begin
          state_d = GAP;
          csn_d   = 1'b1;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          gap_d   = '0;
        end
      end

      GAP: begin
        mosi_d = 1'b0;
        csn_d  = 1'b1;
        if (gap_q == GapLast) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      phase_q <= 1'b0;
      sclk_q  <= CpolBit;
      mosi_q  <= 1'b0;
      csn_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = csn_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_spi_tx_master.sv
// Directed bench for spi_tx_master: four configurations share one clock and reset;
// expected serial bits are queued when a word is driven and popped at each rising sclk.
module tb_spi_tx_master;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0]  data0 = '0;
  logic [7:0]  data1 = '0;
  logic [7:0]  data2 = '0;
  logic [15:0] data3 = '0;
  logic validV[4];
  logic readyV[4];
  logic sclkV[4];
  logic mosiV[4];
  logic csnV[4];
  logic busyV[4];
  logic doneV[4];

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  logic prevSclk = 1'b0;
  logic expQ[$];

  always #5 clk = ~clk;

  spi_tx_master #(.DATA_W(8), .DIV(2), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .CS_GAP(2)) u0 (
    .clk(clk), .rst(rst), .tx_data(data0), .tx_valid(validV[0]), .tx_ready(readyV[0]),
    .sclk(sclkV[0]), .mosi(mosiV[0]), .cs_n(csnV[0]), .busy(busyV[0]), .done(doneV[0]));

  spi_tx_master #(.DATA_W(8), .DIV(2), .CPOL(0), .CPHA(0), .LSB_FIRST(1), .CS_GAP(2)) u1 (
    .clk(clk), .rst(rst), .tx_data(data1), .tx_valid(validV[1]), .tx_ready(readyV[1]),
    .sclk(sclkV[1]), .mosi(mosiV[1]), .cs_n(csnV[1]), .busy(busyV[1]), .done(doneV[1]));

  spi_tx_master #(.DATA_W(8), .DIV(1), .CPOL(1), .CPHA(1), .LSB_FIRST(0), .CS_GAP(2)) u2 (
    .clk(clk), .rst(rst), .tx_data(data2), .tx_valid(validV[2]), .tx_ready(readyV[2]),
    .sclk(sclkV[2]), .mosi(mosiV[2]), .cs_n(csnV[2]), .busy(busyV[2]), .done(doneV[2]));

  spi_tx_master #(.DATA_W(16), .DIV(3), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .CS_GAP(2)) u3 (
    .clk(clk), .rst(rst), .tx_data(data3), .tx_valid(validV[3]), .tx_ready(readyV[3]),
    .sclk(sclkV[3]), .mosi(mosiV[3]), .cs_n(csnV[3]), .busy(busyV[3]), .done(doneV[3]));

  // Single comparison point: counts every check and reports tag/observed/expected on failure.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushWord(input logic [31:0] word, input int w, input bit lsb);
    for (int b = 0; b < w; b++) begin
      expQ.push_back(lsb ? word[b] : word[w-1-b]);
    end
  endtask

  // On a rising sclk the bit on mosi must be the next one the scoreboard expects.
  task automatic sampleEdge(input int s);
    logic expBit;
    if (sclkV[s] === 1'b1 && prevSclk === 1'b0) begin
      rises++;
      checks++;
      assert (expQ.size() != 0) else begin
        errors++;
        $error("[TB] FAIL edgeQueue observed=extra_edge expected=no_edge");
      end
      if (expQ.size() != 0) begin
        expBit = expQ.pop_front();
        checkVal("mosiBit", mosiV[s], expBit);
      end
    end
    prevSclk = sclkV[s];
  endtask

  // Drives one word on instance s; returns right after the accepting edge (end of T0).
  task automatic applyStimulus(input int s, input logic [31:0] word, input int w, input bit lsb);
    @(negedge clk);
    prevSclk = sclkV[s];
    rises = 0;
    pushWord(word, w, lsb);
    case (s)
      0: data0 = word[7:0];
      1: data1 = word[7:0];
      2: data2 = word[7:0];
      default: data3 = word[15:0];
    endcase
    validV[s] = 1'b1;
    checkVal("acceptReady", readyV[s], 1);
    @(posedge clk);
  endtask

  // Follows one frame cycle by cycle; i counts cycles after the accept cycle T0.
  task automatic checkOutput(input int s, input int w, input int expDone, input int expReady,
                             input int expCsLow, input bit changeData);
    int doneCyc;
    int doneCnt;
    int readyCyc;
    int csLow;
    bit fin;
    doneCyc = 0; doneCnt = 0; readyCyc = 0; csLow = 0; fin = 1'b0;
    for (int i = 1; i <= 2000 && !fin; i++) begin
      @(negedge clk);
      if (i == 1) begin
        validV[s] = 1'b0;
        if (changeData) data3 = 16'h1234;
        checkVal("csLowAfterAccept", csnV[s], 0);
        checkVal("busyAfterAccept", busyV[s], 1);
        checkVal("notReadyAfterAccept", readyV[s], 0);
      end
      sampleEdge(s);
      if (csnV[s] === 1'b0) csLow++;
      if (doneV[s] === 1'b1) begin
        doneCnt++;
        doneCyc = i;
      end
      if (readyV[s] === 1'b1) begin
        readyCyc = i;
        fin = 1'b1;
        checkVal("busyFallsWithReady", busyV[s], 0);
      end
    end
    checkVal("frameTimeout", fin, 1);
    checkVal("doneCycle", doneCyc, expDone);
    checkVal("doneCount", doneCnt, 1);
    checkVal("readyCycle", readyCyc, expReady);
    checkVal("csLowCycles", csLow, expCsLow);
    checkVal("risingEdges", rises, w);
    checkVal("queueDrained", expQ.size(), 0);
  endtask

  initial begin
    int doneCnt;
    int gapCyc;
    int readyCyc1;
    int readyCyc2;
    int csFall;
    int doneSeen;
    bit fin;

    for (int k = 0; k < 4; k++) validV[k] = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rstReady", readyV[0], 0);
    checkVal("rstSclkCpol0", sclkV[0], 0);
    checkVal("rstSclkCpol1", sclkV[2], 1);
    checkVal("rstMosi", mosiV[0], 0);
    checkVal("rstCsn", csnV[0], 1);
    checkVal("rstBusy", busyV[0], 0);
    checkVal("rstDone", doneV[0], 0);
    rst = 1'b0;
    @(negedge clk);
    checkVal("readyAfterRelease", readyV[0], 1);
    checkVal("readyAfterReleaseW16", readyV[3], 1);
    $display("[TB] reset checks done");

    // Mode 0, DIV=2, MSB first
    applyStimulus(0, 32'h12, 8, 1'b0);
    checkOutput(0, 8, 1 + 17 * 2, 1 + 17 * 2 + 2, 17 * 2, 1'b0);

    // Same with LSB first
    applyStimulus(1, 32'h12, 8, 1'b1);
    checkOutput(1, 8, 1 + 17 * 2, 1 + 17 * 2 + 2, 17 * 2, 1'b0);

    // Mode 3, DIV=1
    applyStimulus(2, 32'hA5, 8, 1'b0);
    checkOutput(2, 8, 1 + 17, 1 + 17 + 2, 17, 1'b0);
    $display("[TB] single frame checks done");

    // Back-to-back frames with tx_valid held high
    @(negedge clk);
    prevSclk = sclkV[0];
    rises = 0;
    pushWord(32'h01, 8, 1'b0);
    pushWord(32'h80, 8, 1'b0);
    data0 = 8'h01;
    validV[0] = 1'b1;
    @(posedge clk);
    doneCnt = 0; gapCyc = 0; readyCyc1 = 0; readyCyc2 = 0; csFall = 0; fin = 1'b0;
    for (int i = 1; i <= 300 && !fin; i++) begin
      @(negedge clk);
      if (i == 1) data0 = 8'h80;
      sampleEdge(0);
      if (doneV[0] === 1'b1) doneCnt++;
      if (doneCnt == 1 && csnV[0] === 1'b1 && readyV[0] === 1'b0) gapCyc++;
      if (doneCnt == 1 && readyV[0] === 1'b1) readyCyc1 = i;
      if (doneCnt == 1 && readyCyc1 != 0 && csnV[0] === 1'b0 && validV[0] === 1'b1) begin
        csFall = i;
        validV[0] = 1'b0;
      end
      if (doneCnt == 2 && readyV[0] === 1'b1) begin
        readyCyc2 = i;
        fin = 1'b1;
      end
    end
    checkVal("b2bTimeout", fin, 1);
    checkVal("b2bDoneCount", doneCnt, 2);
    checkVal("b2bGapCycles", gapCyc, 2);
    checkVal("b2bFirstReady", readyCyc1, 37);
    checkVal("b2bCsFall", csFall, 38);
    checkVal("b2bSecondReady", readyCyc2, 37 + 37);
    checkVal("b2bRisingEdges", rises, 16);
    checkVal("b2bQueueDrained", expQ.size(), 0);
    $display("[TB] back-to-back checks done");

    // Reset asserted so it lands on the edge that would make k=5
    applyStimulus(0, 32'hC3, 8, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) validV[0] = 1'b0;
      sampleEdge(0);
    end
    rst = 1'b1;
    @(negedge clk);
    checkVal("midRstCsn", csnV[0], 1);
    checkVal("midRstSclk", sclkV[0], 0);
    checkVal("midRstReady", readyV[0], 0);
    checkVal("midRstDone", doneV[0], 0);
    checkVal("midRstBusy", busyV[0], 0);
    rst = 1'b0;
    expQ.delete();
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (doneV[0] === 1'b1) doneSeen++;
    end
    checkVal("noDoneAfterReset", doneSeen, 0);

    applyStimulus(0, 32'h5A, 8, 1'b0);
    checkOutput(0, 8, 1 + 17 * 2, 1 + 17 * 2 + 2, 17 * 2, 1'b0);
    $display("[TB] mid-frame reset checks done");

    // 16-bit word, DIV=3, tx_data changed right after accept
    applyStimulus(3, 32'hF00F, 16, 1'b0);
    checkOutput(3, 16, 1 + 33 * 3, 1 + 33 * 3 + 2, 33 * 3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_tx_master.md
# spi_tx_master

Parametrised SPI transmit master that replaces the fixed 8-bit, fixed-divider serialiser. It accepts words over a valid/ready handshake and shifts them out on sclk/mosi with a framing cs_n. Word width, bit order, SPI mode (CPOL/CPHA), sclk rate and inter-frame gap are configurable. It sits between the FIFO read side and the external SPI device pins.

## Interface
- DATA_W, 8: bits per frame, 2..32
- DIV, 26: clk cycles per sclk half-period, ≥1
- CPOL, 0: sclk idle level
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge
- LSB_FIRST, 0: 1 = shift bit 0 first
- CS_GAP, 2: clk cycles cs_n stays high after a frame before the next accept, ≥1

- clk  in  1  single system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- tx_data  in  DATA_W  word to send; sampled on the accept cycle
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  block can accept; accept = tx_valid && tx_ready
- sclk  out  1  serial clock
- mosi  out  1  serial data
- cs_n  out  1  frame select, active-low
- busy  out  1  high from the cycle after accept until the end of the gap
- done  out  1  one-cycle pulse when cs_n rises

## Operation
- States: IDLE → SHIFT → TRAIL → GAP → IDLE.
- IDLE: tx_ready=1, sclk=CPOL, cs_n=1, mosi=0. On accept: latch tx_data into the shift register, go to SHIFT.
- SHIFT: half-tick counter counts DIV cycles per half-period. Each expiry toggles sclk. Edges are numbered k=1..2·DATA_W; odd k is leading, even k is trailing.
  - CPHA=0: first bit is driven on mosi at SHIFT entry. mosi advances to the next bit on trailing edges k=2,4..2·DATA_W−2.
  - CPHA=1: mosi=0 at SHIFT entry. mosi advances on every leading edge, with the first bit on k=1.
  - After edge 2·DATA_W, go to TRAIL.
- TRAIL: hold sclk=CPOL and mosi for one half-period (DIV cycles). Then set cs_n=1, pulse done, and go to GAP.
- GAP: cs_n=1, mosi=0 for CS_GAP cycles, then go to IDLE.
- Bit order: LSB_FIRST=0 sends tx_data[DATA_W−1] first; LSB_FIRST=1 sends tx_data[0] first.
- tx_data changes after the accept cycle do not affect the frame in flight.
- Counter widths: half-tick counter is $clog2(DIV+1) bits; bit counter is $clog2(DATA_W+1) bits. Neither counter wraps; each is reloaded on state entry.

## Timing
- Reset values (rst high, and the first cycle after release): tx_ready=0, sclk=CPOL, mosi=0, cs_n=1, busy=0, done=0, state IDLE. tx_ready=1 from the first edge with rst low.
- Accept at cycle T0. At T0+1: cs_n=0, busy=1, tx_ready=0.
- Edge k lands at T0+1+k·DIV.
- cs_n rises and done=1 at T0+1+(2·DATA_W+1)·DIV.
- tx_ready=1 at T0+1+(2·DATA_W+1)·DIV+CS_GAP.
- busy falls in the same cycle tx_ready rises.
- tx_valid held high continuously gives back-to-back frames separated by exactly CS_GAP cycles of cs_n high.
- tx_valid while not ready is ignored; it is neither queued nor dropped silently as an error.
- DIV=1: sclk toggles every clk, giving a clk/2 rate. All relations above still hold.
- Reset mid-frame: the next edge forces the reset values, the frame is discarded, and no done pulse is generated.

## Structure
- Package spi_pkg holds the state enum (IDLE, SHIFT, TRAIL, GAP) and the mode localparams MODE0..MODE3 as {CPOL,CPHA}.
- Sub-module spi_tick_gen is the DIV half-period counter. Inputs are clk, rst, run; output is a one-cycle tick. It restarts from 0 when run rises.
- The FSM, shift register and output registers live in spi_tx_master. All outputs are registered except tx_ready, which is decoded from state and gated by !rst.

## Test plan
- DATA_W=8, DIV=2, mode 0, MSB first, send 0x12 → mosi at rising sclk edges = 0,0,0,1,0,0,1,0; exactly 8 rising edges; done at T0+35; tx_ready at T0+37.
- Same configuration with LSB_FIRST=1, send 0x12 → sampled bits 0,1,0,0,1,0,0,0.
- Mode 3 (CPOL=1, CPHA=1), DIV=1, send 0xA5 → sclk idles high; bits 1,0,1,0,0,1,0,1 are stable at each rising (trailing) edge; cs_n low for 17 cycles.
- tx_valid held high with 0x01 then 0x80 → two frames with cs_n high for exactly CS_GAP=2 cycles between them; done pulses once per frame.
- rst asserted at edge k=5 of a frame → the next cycle shows cs_n=1, sclk=CPOL, tx_ready=0; no done pulse; a new frame after release is sent intact.
- DATA_W=16, DIV=3, send 0xF00F with tx_data changed on T0+1 → mosi still carries 0xF00F; done at T0+1+33·3.
